// File: rtl/pipe_stage_chain_pkg.sv
// pipe_pkg: definitions shared by the pipeline register chain and its users.
//   MAX_DEPTH        - deepest chain the design is sized and checked for.
//   *_W / *_LSB      - field layout of a MEM/WB payload packed into one vector.
//   wb_sel_t         - write-back source select encoding.
//   pack_mem_wb()    - assembles a MEM/WB payload from its fields.
package pipe_pkg;

    localparam int MAX_DEPTH = 8;

    // MEM/WB payload field widths
    localparam int RD_W     = 5;
    localparam int PC4_W    = 32;
    localparam int ALU_W    = 32;
    localparam int IMM_W    = 32;
    localparam int DMEM_W   = 32;
    localparam int WB_SEL_W = 2;
    localparam int REG_WE_W = 1;

    // MEM/WB payload field offsets, REG_WE in the least significant bit
    localparam int REG_WE_LSB = 0;
    localparam int WB_SEL_LSB = REG_WE_LSB + REG_WE_W;
    localparam int DMEM_LSB   = WB_SEL_LSB + WB_SEL_W;
    localparam int IMM_LSB    = DMEM_LSB + DMEM_W;
    localparam int ALU_LSB    = IMM_LSB + IMM_W;
    localparam int PC4_LSB    = ALU_LSB + ALU_W;
    localparam int RD_LSB     = PC4_LSB + PC4_W;
    localparam int MEM_WB_W   = RD_LSB + RD_W;   // 136

    typedef enum logic [WB_SEL_W-1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2,
        WB_SEL_IMM = 2'd3
    } wb_sel_t;

    function automatic logic [MEM_WB_W-1:0] pack_mem_wb(
        input logic [RD_W-1:0]   rd,
        input logic [PC4_W-1:0]  pc_4,
        input logic [ALU_W-1:0]  alu,
        input logic [IMM_W-1:0]  imm,
        input logic [DMEM_W-1:0] dmem,
        input wb_sel_t           wb_sel,
        input logic              reg_we
    );
        return {rd, pc_4, alu, imm, dmem, wb_sel, reg_we};
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: handshake/control bundle of the pipeline register chain.
//   Upstream side : IN_VALID, IN_READY, IN_DATA
//   Downstream    : OUT_VALID, OUT_READY, OUT_DATA, OUT_COUNT
//   Control       : BUSYWAIT (global freeze), FLUSH (squash all slots)
//   Optional      : STALL_CNT, BUBBLE_CNT when PIPE_PERF_CNT_EN is defined.
// Modports: slave = the chain itself, master = the environment driving it.
interface pipe_stage_chain_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] IN_DATA;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [DATA_W-1:0] OUT_DATA;
    logic              BUSYWAIT;
    logic              FLUSH;
    logic [CNT_W-1:0]  OUT_COUNT;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]       STALL_CNT;
    logic [31:0]       BUBBLE_CNT;

    modport slave (
        input  IN_VALID, IN_DATA, OUT_READY, BUSYWAIT, FLUSH,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_COUNT, STALL_CNT, BUBBLE_CNT
    );
    modport master (
        output IN_VALID, IN_DATA, OUT_READY, BUSYWAIT, FLUSH,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_COUNT, STALL_CNT, BUBBLE_CNT
    );
`else
    modport slave (
        input  IN_VALID, IN_DATA, OUT_READY, BUSYWAIT, FLUSH,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_COUNT
    );
    modport master (
        output IN_VALID, IN_DATA, OUT_READY, BUSYWAIT, FLUSH,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_COUNT
    );
`endif
endinterface

// File: rtl/pipe_stage_chain_slot.sv
// pipe_stage_slot: one valid+data register of the chain.
//   CLK, RESET : clock and synchronous active-high reset (clears valid and data)
//   flush      : clears valid, keeps data
//   load       : stage may advance; valid follows src_valid, data only
//                captured when src_valid is set (bubbles do not overwrite data)
//   valid/data : registered slot contents
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              flush,
    input  logic              load,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= src_valid;
            if (src_valid) begin
                data_reg <= src_data;
            end
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage payload register chain with valid/ready
// handshake, BUSYWAIT freeze and FLUSH squash. Empty stages keep accepting
// data while later stages stall, so bubbles collapse.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : pipe_stage_chain_if.slave (IN_*, OUT_*, BUSYWAIT, FLUSH,
//                OUT_COUNT, and STALL_CNT/BUBBLE_CNT when PIPE_PERF_CNT_EN
//                is defined)
// Edge priority: RESET > FLUSH > BUSYWAIT > normal advance.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                CLK,
    input  logic                RESET,
    pipe_stage_chain_if.slave   bus
);

    logic [DEPTH-1:0]  valid_reg;
    logic [DATA_W-1:0] data_reg  [DEPTH];
    logic [DEPTH-1:0]  rdy;
    logic [DEPTH-1:0]  src_valid;
    logic [DATA_W-1:0] src_data  [DEPTH];
    logic [CNT_W-1:0]  count_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            // Flattened form of the ready chain: a stage may advance when the
            // consumer is taking data or any stage from here to the output
            // is empty. Avoids a self-referencing combinational vector.
            assign rdy[gi] = bus.OUT_READY | ~(&valid_reg[DEPTH-1:gi]);

            if (gi == 0) begin : g_src_in
                assign src_valid[gi] = bus.IN_VALID;
                assign src_data[gi]  = bus.IN_DATA;
            end else begin : g_src_prev
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_data[gi]  = data_reg[gi-1];
            end

            pipe_stage_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .CLK       (CLK),
                .RESET     (RESET),
                .flush     (bus.FLUSH),
                .load      (rdy[gi] & ~bus.BUSYWAIT),
                .src_valid (src_valid[gi]),
                .src_data  (src_data[gi]),
                .valid     (valid_reg[gi]),
                .data      (data_reg[gi])
            );
        end
    endgenerate

    always_comb begin
        count_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_next = count_next + CNT_W'(valid_reg[k]);
        end
    end

    assign bus.IN_READY  = rdy[0] & ~bus.BUSYWAIT & ~bus.FLUSH & ~RESET;
    assign bus.OUT_VALID = valid_reg[DEPTH-1];
    assign bus.OUT_DATA  = data_reg[DEPTH-1];
    assign bus.OUT_COUNT = count_next;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] bubble_cnt_reg;

    // Saturating event counters: a stall is a frozen cycle or an unconsumed
    // output, a bubble is any cycle with nothing presented downstream.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if ((bus.BUSYWAIT | (valid_reg[DEPTH-1] & ~bus.OUT_READY))
                && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (!valid_reg[DEPTH-1] && (bubble_cnt_reg != 32'hFFFF_FFFF)) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
        end
    end

    assign bus.STALL_CNT  = stall_cnt_reg;
    assign bus.BUBBLE_CNT = bubble_cnt_reg;
`endif

endmodule
